// File: rtl/alu_pipe_arith.sv
// -----------------------------------------------------------------------------
// alu_pipe_arith
//   Pipelined integer ALU: ADD / SUB / AND / OR / XOR with carry, signed
//   overflow, zero, negative and illegal-opcode flags. The operation is
//   evaluated combinationally in front of stage 0; stages 1..PIPE_DEPTH-1 are
//   plain delay registers. The result is visible PIPE_DEPTH cycles after the
//   beat is accepted.
//
// Parameters
//   WIDTH       operand/result width (>= 2)
//   PIPE_DEPTH  register stages between accept and output (1..4)
//
// Optional feature macro
//   ALU_SAT_EN  when defined, ADD/SUB results that overflow are clamped to the
//               signed max/min; when undefined, they wrap modulo 2^WIDTH.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   en         pipeline enable, 0 freezes every stage
//   in_valid   operand beat valid       in_ready  block accepts a beat
//   a, b       operands                 opcode    000 ADD 001 SUB 010 AND
//                                                 011 OR  100 XOR 101-111 illegal
//   out_valid  result beat valid        out_ready consumer accepts result
//   result     operation result
//   flag_c     carry-out (ADD) / not-borrow (SUB)
//   flag_v     signed overflow (ADD/SUB)
//   flag_z     result == 0              flag_n    result MSB
//   illegal    opcode was 101..111
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// in the cycle before that edge. The whole pipe advances as one unit
// (advance = en & (~out_valid | out_ready)), so in_ready is that same signal;
// empty slots are carried as bubbles and are never collapsed.
// -----------------------------------------------------------------------------
module alu_pipe_arith #(
    parameter int WIDTH      = 16,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             illegal
);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic             c;
        logic             v;
        logic             z;
        logic             n;
        logic             ill;
    } beat_t;

    beat_t            beat_d;
    beat_t            stage_q [PIPE_DEPTH];
    logic             advance;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;
    logic             ill_d;

    assign advance  = en & (~out_valid | out_ready);
    assign in_ready = advance;

    // Stage-0 evaluation. SUB reuses the adder as a + ~b + 1, so the carry
    // out is the not-borrow bit and the overflow test uses the inverted b.
    always_comb begin
        is_sub = (opcode == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        res_d  = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        ill_d  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                c_d = sum[WIDTH];
                v_d = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]);
`ifdef ALU_SAT_EN
                // Overflow direction follows a's sign: positive operands
                // overflow upward, negative ones downward.
                if (v_d) begin
                    res_d = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
                end else begin
                    res_d = sum[MSB:0];
                end
`else
                res_d = sum[MSB:0];
`endif
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            default: ill_d = 1'b1;
        endcase

        // Bubbles carry an all-zero payload so idle outputs read as zero.
        beat_d = '0;
        if (in_valid) begin
            beat_d.valid  = 1'b1;
            beat_d.result = res_d;
            beat_d.c      = c_d;
            beat_d.v      = v_d;
            beat_d.z      = (res_d == '0);
            beat_d.n      = res_d[MSB];
            beat_d.ill    = ill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            stage_q[0] <= beat_d;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid = stage_q[PIPE_DEPTH-1].valid;
    assign result    = stage_q[PIPE_DEPTH-1].result;
    assign flag_c    = stage_q[PIPE_DEPTH-1].c;
    assign flag_v    = stage_q[PIPE_DEPTH-1].v;
    assign flag_z    = stage_q[PIPE_DEPTH-1].z;
    assign flag_n    = stage_q[PIPE_DEPTH-1].n;
    assign illegal   = stage_q[PIPE_DEPTH-1].ill;

endmodule

// File: tb/tb_alu_pipe_arith.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_arith
//   Bench for alu_pipe_arith (WIDTH=16, PIPE_DEPTH=2). Expected results are
//   queued when a beat is accepted and compared when the DUT hands a result
//   over. Define ALU_SAT_EN for both files to exercise the clamping build.
// -----------------------------------------------------------------------------
module tb_alu_pipe_arith;
    localparam int W     = 16;
    localparam int DEPTH = 2;
    localparam int EW    = W + 5;  // {result, c, v, z, n, illegal}

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_c;
    logic          flag_v;
    logic          flag_z;
    logic          flag_n;
    logic          illegal;

    logic [EW-1:0] drv_exp;
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            passed = 0;
    bit            rand_run;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2:0]    op;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t vecs [13];

    alu_pipe_arith #(.WIDTH(W), .PIPE_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .illegal   (illegal)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma,
                                            input logic [W-1:0] mb,
                                            input logic [2:0]   op);
        int         ua, ub, sa, ss;
        int         smax, smin;
        logic [W-1:0] r;
        logic       c, v, ill;
        ua   = ma;
        ub   = mb;
        sa   = $signed(ma);
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            3'd0: begin
                ss = sa + $signed(mb);
                r  = W'(ua + ub);
                c  = (ua + ub) >= (1 << W);
                v  = (ss > smax) || (ss < smin);
            end
            3'd1: begin
                ss = sa - $signed(mb);
                r  = W'(ua - ub);
                c  = (ua >= ub);
                v  = (ss > smax) || (ss < smin);
            end
            3'd2: r = ma & mb;
            3'd3: r = ma | mb;
            3'd4: r = ma ^ mb;
            default: ill = 1'b1;
        endcase
`ifdef ALU_SAT_EN
        if (v) r = (ss > 0) ? W'(smax) : W'(smin);
`endif
        return {r, c, v, (r == '0), r[W-1], ill};
    endfunction

    // ---------------- scoreboard ----------------
    // Sampled on the falling edge: inputs change just after the rising edge,
    // so what is seen here is what the next rising edge will act on.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        if (rst_n && en && out_valid && out_ready) begin
            got = {result, flag_c, flag_v, flag_z, flag_n, illegal};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_out got=%h exp=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got === e) passed++;
                else $display("FAIL out_beat got=%h exp=%h", got, e);
            end
        end
        if (rst_n && in_valid && in_ready) exp_q.push_back(drv_exp);
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb,
                        input logic [2:0] sop, input logic [EW-1:0] sexp);
        bit ok = 1'b0;
        a = sa; b = sb; opcode = sop; drv_exp = sexp; in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout got=no_ready exp=ready");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check(name, exp_q.size(), 0);
        idle(2);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            default: return W'($urandom_range(0, 65535));
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rop;

        vecs[0]  = '{16'h7FFF, 16'h0001, 3'd0, {16'h8000, 5'b01010}};
`ifdef ALU_SAT_EN
        vecs[0]  = '{16'h7FFF, 16'h0001, 3'd0, {16'h7FFF, 5'b01000}};
`endif
        vecs[1]  = '{16'h0005, 16'h0005, 3'd1, {16'h0000, 5'b10100}};
        vecs[2]  = '{16'h0000, 16'h0001, 3'd1, {16'hFFFF, 5'b00010}};
        vecs[3]  = '{16'h0001, 16'h0001, 3'd0, {16'h0002, 5'b00000}};
        vecs[4]  = '{16'hF0F0, 16'h0FF0, 3'd4, {16'hFF00, 5'b00010}};
        vecs[5]  = '{16'hABCD, 16'h1234, 3'd7, {16'h0000, 5'b00101}};
        vecs[6]  = '{16'hFFFF, 16'h0001, 3'd0, {16'h0000, 5'b10100}};
        vecs[7]  = '{16'h8000, 16'h0001, 3'd1, {16'h7FFF, 5'b11000}};
`ifdef ALU_SAT_EN
        vecs[7]  = '{16'h8000, 16'h0001, 3'd1, {16'h8000, 5'b11010}};
`endif
        vecs[8]  = '{16'hF0F0, 16'h0FF0, 3'd2, {16'h00F0, 5'b00000}};
        vecs[9]  = '{16'hF000, 16'h000F, 3'd3, {16'hF00F, 5'b00010}};
        vecs[10] = '{16'h1234, 16'h5678, 3'd5, {16'h0000, 5'b00101}};
        vecs[11] = '{16'h8000, 16'h8000, 3'd0, {16'h0000, 5'b11100}};
`ifdef ALU_SAT_EN
        vecs[11] = '{16'h8000, 16'h8000, 3'd0, {16'h8000, 5'b11010}};
`endif
        vecs[12] = '{16'h0003, 16'h0005, 3'd1, {16'hFFFE, 5'b00010}};

        // reset state
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; opcode = '0; drv_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_c, flag_v, flag_z, flag_n, illegal}, 0);
        check("rst_in_ready", in_ready, 1);

        // table vectors, streamed back to back
        for (int i = 0; i < 13; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
        drain("table_drain");

        // latency and back-to-back: results on cycles 2, 3, 4
        send(16'h0001, 16'h0001, 3'd0, {16'h0002, 5'b00000});
        check("lat_c1_valid", out_valid, 0);
        send(16'hF0F0, 16'h0FF0, 3'd4, {16'hFF00, 5'b00010});
        check("lat_c2_valid", out_valid, 1);
        check("lat_c2_result", result, 16'h0002);
        send(16'h0000, 16'h0000, 3'd7, {16'h0000, 5'b00101});
        check("lat_c3_result", result, 16'hFF00);
        idle(1);
        check("lat_c4_result", result, 16'h0000);
        check("lat_c4_ill_z", {illegal, flag_z}, 2'b11);
        idle(1);
        check("lat_c5_valid", out_valid, 0);
        drain("b2b_drain");

        // backpressure: 4 beats with out_ready low, exactly 2 held
        out_ready = 1'b0;
        fork
            begin
                send(16'd10,  16'd20,  3'd0, model(16'd10, 16'd20, 3'd0));
                send(16'd100, 16'd1,   3'd1, model(16'd100, 16'd1, 3'd1));
                send(16'h00F0, 16'h0F00, 3'd3, model(16'h00F0, 16'h0F00, 3'd3));
                send(16'h0FF0, 16'h00FF, 3'd2, model(16'h0FF0, 16'h00FF, 3'd2));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check("bp_in_ready", in_ready, 0);
                check("bp_valid", out_valid, 1);
                check("bp_result_a", result, 16'd30);
                check("bp_queued", exp_q.size(), 2);
                repeat (2) @(posedge clk);
                #1;
                check("bp_result_b", result, 16'd30);
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // enable low for 3 cycles mid-stream
        fork
            begin
                send(16'h0010, 16'h0001, 3'd0, model(16'h0010, 16'h0001, 3'd0));
                send(16'h0100, 16'h0023, 3'd0, model(16'h0100, 16'h0023, 3'd0));
                send(16'h5555, 16'hAAAA, 3'd4, model(16'h5555, 16'hAAAA, 3'd4));
                send(16'h0007, 16'h0009, 3'd1, model(16'h0007, 16'h0009, 3'd1));
                send(16'h7FFF, 16'h7FFF, 3'd0, model(16'h7FFF, 16'h7FFF, 3'd0));
            end
            begin
                repeat (3) @(posedge clk);
                #1 en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check("en_in_ready", in_ready, 0);
                    check("en_valid", out_valid, 1);
                    check("en_result", result, 16'h0123);
                end
                en = 1'b1;
            end
        join
        drain("en_drain");

        // reset with 2 beats in flight
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 3'd0, model(16'h1111, 16'h2222, 3'd0));
        send(16'h0F0F, 16'h0F0F, 3'd1, model(16'h0F0F, 16'h0F0F, 3'd1));
        check("fl_queued", exp_q.size(), 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        check("fl_valid", out_valid, 0);
        check("fl_result", result, 0);
        check("fl_flags", {flag_c, flag_v, flag_z, flag_n, illegal}, 0);
        out_ready = 1'b1;
        idle(6);
        check("fl_no_stale", out_valid, 0);
        send(16'h0002, 16'h0003, 3'd0, {16'h0005, 5'b00000});
        drain("fl_drain");

        // random traffic with random backpressure and enable
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    ra  = pick();
                    rb  = pick();
                    rop = 3'($urandom_range(0, 7));
                    send(ra, rb, rop, model(ra, rb, rop));
                end
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    en        = ($urandom_range(0, 7) != 0);
                end
                out_ready = 1'b1;
                en        = 1'b1;
            end
        join
        drain("rand_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
